// File: rtl/pwm_mixer_n.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_mixer_n
//  Purpose  : N-channel quadrature-encoder controlled PWM mixer. Each channel
//             synchronises and debounces its encoder pins, steps a level
//             register per detent and drives a PWM output whose duty is
//             reloaded only at PWM period boundaries.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_mixer_n #(
   parameter int NCH        = 3,
   parameter int WIDTH      = 8,
   parameter int DB_CYCLES  = 16,
   parameter int PRESCALE   = 256,
   parameter int STEP       = 1,
   parameter int SATURATE   = 1,
   parameter int INIT_LEVEL = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCH-1:0]       enc_a,
   input  logic [NCH-1:0]       enc_b,
   output logic [NCH-1:0]       pwm_out,
   output logic [NCH*WIDTH-1:0] level,
   output logic                 period_start
);

   // A and B pins share one sync/debounce datapath: A pins low, B pins high.
   localparam int c_npin = 2 * NCH;
   localparam int c_dbw  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int c_pw   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   localparam logic [c_dbw-1:0] c_db_last   = c_dbw'(DB_CYCLES - 1);
   localparam logic [c_pw-1:0]  c_pcnt_last = c_pw'(PRESCALE - 1);
   // Last PWM count is 2**WIDTH-2 so the period is 2**WIDTH-1 ticks and a
   // full-scale duty gives a constant high output.
   localparam logic [WIDTH-1:0] c_cnt_last  = {{(WIDTH-1){1'b1}}, 1'b0};
   localparam logic [WIDTH-1:0] c_lvl_max   = {WIDTH{1'b1}};
   localparam logic [WIDTH:0]   c_step      = (WIDTH+1)'(STEP);
   localparam logic [WIDTH-1:0] c_init      = WIDTH'(INIT_LEVEL);

   logic [c_npin-1:0] w_pins;
   logic [c_npin-1:0] r_sync1;
   logic [c_npin-1:0] r_sync2;
   logic              r_db     [c_npin];
   logic [c_dbw-1:0]  r_db_cnt [c_npin];
   logic [NCH-1:0]    w_a_db;
   logic [NCH-1:0]    w_b_db;
   logic [NCH-1:0]    r_a_prev;
   logic [WIDTH-1:0]  r_level  [NCH];
   logic [WIDTH-1:0]  r_duty   [NCH];
   logic [NCH-1:0]    r_pwm;
   logic [c_pw-1:0]   r_pcnt;
   logic [WIDTH-1:0]  r_pwm_cnt;
   logic              r_period_start;
   logic              w_tick;
   logic              w_wrap;

   assign w_pins = {enc_b, enc_a};

   // Two-flop synchroniser for every encoder pin.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_pins;
         r_sync2 <= r_sync1;
      end
   end

   generate
      for (genvar p = 0; p < c_npin; p++) begin : g_db
         // Debounce: accept a new value only after DB_CYCLES stable cycles.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_db[p]     <= 1'b0;
               r_db_cnt[p] <= '0;
            end else if (r_sync2[p] == r_db[p]) begin
               r_db_cnt[p] <= '0;
            end else if (r_db_cnt[p] == c_db_last) begin
               r_db[p]     <= r_sync2[p];
               r_db_cnt[p] <= '0;
            end else begin
               r_db_cnt[p] <= r_db_cnt[p] + 1'b1;
            end
         end
      end
   endgenerate

   // Previous debounced A value for rising-edge detent detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_a_prev <= '0;
      end else begin
         r_a_prev <= w_a_db;
      end
   end

   generate
      for (genvar i = 0; i < NCH; i++) begin : g_ch
         logic [WIDTH:0]   w_up;
         logic [WIDTH:0]   w_dn;
         logic [WIDTH-1:0] w_next;

         assign w_a_db[i] = r_db[i];
         assign w_b_db[i] = r_db[NCH + i];

         // Extra MSB carries the overflow / borrow used for clamping.
         assign w_up = {1'b0, r_level[i]} + c_step;
         assign w_dn = {1'b0, r_level[i]} - c_step;

         // Next level: step on a rising A edge, direction chosen by B.
         always_comb begin
            w_next = r_level[i];
            if (w_a_db[i] && !r_a_prev[i]) begin
               if (!w_b_db[i]) begin
                  w_next = (SATURATE != 0 && w_up > {1'b0, c_lvl_max}) ? c_lvl_max : w_up[WIDTH-1:0];
               end else begin
                  w_next = (SATURATE != 0 && w_dn[WIDTH]) ? '0 : w_dn[WIDTH-1:0];
               end
            end
         end

         // Level register, one clock after the detent is seen.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_level[i] <= c_init;
            end else begin
               r_level[i] <= w_next;
            end
         end

         assign level[i*WIDTH +: WIDTH] = r_level[i];
      end
   endgenerate

   assign w_tick = (r_pcnt == c_pcnt_last);
   assign w_wrap = w_tick && (r_pwm_cnt == c_cnt_last);

   // Prescaler producing one PWM tick every PRESCALE clocks.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pcnt <= '0;
      end else if (w_tick) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + 1'b1;
      end
   end

   // Shared PWM counter and period-start strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pwm_cnt      <= '0;
         r_period_start <= 1'b0;
      end else begin
         r_period_start <= w_wrap;
         if (w_wrap) begin
            r_pwm_cnt <= '0;
         end else if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
         end
      end
   end

   // Duty reloads only at the period boundary so a running period never
   // sees a mid-period level change; outputs compare against the count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NCH; i++) begin
            r_duty[i] <= c_init;
         end
         r_pwm <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (w_wrap) begin
               r_duty[i] <= r_level[i];
            end
            r_pwm[i] <= (r_pwm_cnt < r_duty[i]);
         end
      end
   end

   assign pwm_out      = r_pwm;
   assign period_start = r_period_start;

endmodule
`default_nettype wire
